// File: rtl/mesh_router.sv
// Parametrised 5-port XY mesh router: FWFT input FIFOs, per-output round-robin
// arbitration, credit-based flow control and sticky error flags.
module mesh_router #(
    parameter int         XCOORD  = 0,
    parameter int         YCOORD  = 0,
    parameter int         COORD_W = 4,
    parameter int         FLIT_W  = 16,
    parameter int         DEPTH   = 4,
    parameter logic [4:0] PORT_EN = 5'b11111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*FLIT_W-1:0] in_data,
    input  logic [4:0]          in_valid,
    output logic [4:0]          credit_o,
    output logic [5*FLIT_W-1:0] out_data,
    output logic [4:0]          out_valid,
    input  logic [4:0]          credit_i,
    output logic                err_unroutable,
    output logic                err_overflow
);
    localparam int NP = 5;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0]      LAST_PTR = PW'(DEPTH - 1);
    localparam logic [COORD_W-1:0] MY_X     = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(YCOORD);

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    logic [FLIT_W-1:0] fifo_mem   [NP][DEPTH];
    logic [PW-1:0]     rd_ptr     [NP];
    logic [PW-1:0]     wr_ptr     [NP];
    logic [CW-1:0]     fifo_cnt   [NP];
    logic [CW-1:0]     credit_cnt [NP];
    logic [2:0]        rr_ptr     [NP];

    logic [FLIT_W-1:0] head      [NP];
    port_e             route     [NP];
    logic [NP-1:0]     req       [NP];
    logic [2:0]        grant_idx [NP];
    logic [2:0]        cand;
    logic [NP-1:0]     not_empty, unroutable, grant_valid, pop;
    logic [NP-1:0]     wr_accept, wr_drop, credit_inc, credit_sat;

    function automatic logic [2:0] rr_next(input logic [2:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NP) sum = sum - NP;
        return 3'(sum);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    // Dimension-order routing decision taken from each FIFO head
    always_comb begin
        not_empty  = '0;
        unroutable = '0;
        for (int p = 0; p < NP; p++) begin
            head[p]      = fifo_mem[p][rd_ptr[p]];
            not_empty[p] = PORT_EN[p] && (fifo_cnt[p] != '0);
            if (head[p][2*COORD_W-1:COORD_W] > MY_X)
                route[p] = PORT_E;
            else if (head[p][2*COORD_W-1:COORD_W] < MY_X)
                route[p] = PORT_W;
            else if (head[p][COORD_W-1:0] > MY_Y)
                route[p] = PORT_S;
            else if (head[p][COORD_W-1:0] < MY_Y)
                route[p] = PORT_N;
            else
                route[p] = PORT_L;
            unroutable[p] = not_empty[p] && !PORT_EN[route[p]];
        end
    end

    // Each input requests only one output, so per-output grants never collide
    always_comb begin
        grant_valid = '0;
        pop         = '0;
        cand        = '0;
        for (int o = 0; o < NP; o++) begin
            grant_idx[o] = '0;
            req[o]       = '0;
            for (int i = 0; i < NP; i++)
                req[o][i] = not_empty[i] && PORT_EN[o] && (route[i] == 3'(o));
            if (credit_cnt[o] != '0) begin
                for (int k = 0; k < NP; k++) begin
                    cand = rr_next(rr_ptr[o], k);
                    if (!grant_valid[o] && req[o][cand]) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = cand;
                    end
                end
            end
            if (grant_valid[o])
                pop[grant_idx[o]] = 1'b1;
        end
        pop = pop | unroutable;
    end

    always_comb begin
        wr_accept  = '0;
        wr_drop    = '0;
        credit_inc = '0;
        credit_sat = '0;
        for (int p = 0; p < NP; p++) begin
            if (PORT_EN[p] && in_valid[p]) begin
                if (fifo_cnt[p] != FULL_CNT || pop[p])
                    wr_accept[p] = 1'b1;
                else
                    wr_drop[p] = 1'b1;
            end
            credit_inc[p] = PORT_EN[p] && credit_i[p];
            credit_sat[p] = credit_inc[p] && !grant_valid[p] && (credit_cnt[p] == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (!rst && wr_accept[p])
                fifo_mem[p][wr_ptr[p]] <= in_data[p*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                rd_ptr[p]     <= '0;
                wr_ptr[p]     <= '0;
                fifo_cnt[p]   <= '0;
                credit_cnt[p] <= FULL_CNT;
                rr_ptr[p]     <= '0;
            end
            out_valid      <= '0;
            out_data       <= '0;
            credit_o       <= '0;
            err_unroutable <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (wr_accept[p])
                    wr_ptr[p] <= ptr_inc(wr_ptr[p]);
                if (pop[p])
                    rd_ptr[p] <= ptr_inc(rd_ptr[p]);
                if (wr_accept[p] && !pop[p])
                    fifo_cnt[p] <= fifo_cnt[p] + CW'(1);
                else if (!wr_accept[p] && pop[p])
                    fifo_cnt[p] <= fifo_cnt[p] - CW'(1);
                // A send and a returned credit in the same cycle cancel out
                if (grant_valid[p] && !credit_inc[p])
                    credit_cnt[p] <= credit_cnt[p] - CW'(1);
                else if (credit_inc[p] && !grant_valid[p] && credit_cnt[p] != FULL_CNT)
                    credit_cnt[p] <= credit_cnt[p] + CW'(1);
                if (grant_valid[p])
                    rr_ptr[p] <= rr_next(grant_idx[p], 1);
                out_data[p*FLIT_W +: FLIT_W] <= grant_valid[p] ? head[grant_idx[p]] : '0;
            end
            out_valid      <= grant_valid;
            credit_o       <= pop & PORT_EN;
            err_unroutable <= err_unroutable | (|unroutable);
            err_overflow   <= err_overflow | (|wr_drop) | (|credit_sat);
        end
    end
endmodule

// File: doc/mesh_router.md
# mesh_router

Parametrised 5-port mesh NOC router, the generalised successor of the fixed-position corner/edge routers. Port presence is selected by a mask, so one module serves corner, edge and centre tiles. Flit width, input-FIFO depth and coordinates are parameters. Per-output round-robin arbitration and credit flow control are built in, plus sticky error flags. It sits at every mesh tile between neighbour routers and the local network interface.

## Interface
- XCOORD, 0: tile X coordinate; X increases eastward.
- YCOORD, 0: tile Y coordinate; Y increases southward.
- COORD_W, 4: bits per coordinate.
- FLIT_W, 16: flit width; must be ≥ 2*COORD_W.
- DEPTH, 4: input FIFO depth per port, ≥2. Also the reset credit count per output.
- PORT_EN, 5'b11111: port present mask; bit order {L,W,E,S,N}. Index 0=N, 1=S, 2=E, 3=W, 4=L.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  5*FLIT_W  flit from upstream; port p occupies [p*FLIT_W +: FLIT_W].
- in_valid  in  5  write strobe per input port.
- credit_o  out  5  one-cycle pulse per input port; returns one credit upstream.
- out_data  out  5*FLIT_W  flit to downstream, packed as in_data.
- out_valid  out  5  flit-valid strobe per output port.
- credit_i  in  5  one-cycle pulse; downstream freed one slot.
- err_unroutable  out  1  sticky; a flit targeted an absent port.
- err_overflow  out  1  sticky; write to a full FIFO, or credit counter overflow.

## Operation
- Flits are single-flit packets.
  - dest_x = flit[2*COORD_W-1:COORD_W]; dest_y = flit[COORD_W-1:0].
  - Remaining bits are payload and pass through unmodified.
- Input FIFO per present port, DEPTH entries, first-word-fall-through.
  - in_valid on a full FIFO: flit dropped, err_overflow set.
- Route (XY, dimension-order), computed from the FIFO head:
  - dest_x>XCOORD → E; dest_x<XCOORD → W.
  - else dest_y>YCOORD → S; dest_y<YCOORD → N.
  - else → L.
- Unroutable flit: the computed output has its PORT_EN bit clear.
  - The flit is popped and discarded.
  - credit_o is pulsed for that input.
  - err_unroutable is set.
- Credit counter per present output: reset value DEPTH, width $clog2(DEPTH+1).
  - Decrement on send; increment on credit_i.
  - Both in the same cycle: counter unchanged.
  - Increment at DEPTH: counter saturates, err_overflow set.
- Arbiter per output: round-robin over the 5 inputs.
  - Request = FIFO non-empty AND head routes to this output.
  - Grant only if the output's credit counter > 0.
  - Search starts at the priority pointer. After a grant, the pointer moves to winner+1 mod 5; it is unchanged if no grant.
  - Pointers reset to 0.
- Each input requests exactly one output per cycle, so no input receives two grants. Up to 5 flits move per cycle.
- On grant:
  - Head popped; credit_o[input] pulses.
  - out_data/out_valid registered for the output.
- Absent ports:
  - in_valid/credit_i ignored.
  - out_valid, out_data, credit_o held 0.

## Timing
- Reset values:
  - out_valid=0, out_data=0, credit_o=0, err flags=0.
  - FIFOs empty; credit counters = DEPTH; priority pointers = 0.
- Latency: in_valid at edge T → out_valid high after edge T+1, assuming uncongested and credit available. That is 1 cycle of FIFO write plus 1 registered output stage.
- credit_o is registered and pulses the cycle after the pop, i.e. aligned with the flit's out_valid.
- Throughput: 1 flit/cycle per output; back-to-back grants allowed.
- credit_i arriving the same cycle a counter reads 0 does not enable a grant that cycle. The grant occurs the next cycle.
- FIFO write and pop on the same cycle while full: write accepted; occupancy unchanged.
- rst mid-traffic: all FIFO contents and in-flight outputs discarded next cycle. Credits return to DEPTH; no credit_o pulses are issued for discarded flits.
- Error flags clear only on rst.

## Test plan
- XCOORD=1, YCOORD=1, all ports. L injects dest (3,1) payload 0xAB at T → out_valid[E] at T+1, flit unchanged, credit_o[L] at T+1; dest (1,0) → N; dest (1,1) → L.
- Contention: N, S, W inject flits all to E on the same cycle → E emits W... no: in_valid to E-bound flits from N, S, W in one cycle → E emits in order N, S, W on consecutive cycles. Pointer then sits at 4; a new N+W pair goes N first.
- Credit stall: drive no credit_i on E; send DEPTH+2 flits to E → DEPTH flits emitted, then stall. One credit_i[E] pulse → exactly one more flit follows the cycle after.
- PORT_EN=5'b10110 (corner). L sends dest routing W → flit dropped, err_unroutable=1, credit_o[L] pulses, no out_valid anywhere.
- Overflow: block output E, write DEPTH+1 flits on input W → err_overflow=1; after credits return, exactly DEPTH flits exit.
- Assert rst with 3 flits queued → next cycle all outputs 0, flags 0; after release, DEPTH flits are accepted without error.
